// File: rtl/io_port_hub_if.sv
// Processor IO bus and per-channel UART signals for the IO port hub.
// The slave modport is the hub's view. The master modport is the view of the
// processor and the UARTs that surround the hub.
interface io_port_hub_if #(
  parameter int N = 2
) ();
  logic [7:0]     IO_port_ID;
  logic [7:0]     IO_write_data;
  logic           IO_write_strobe;
  logic           IO_read_strobe;
  logic [7:0]     IO_read_data;
  logic [8*N-1:0] ch_tx_data;
  logic [N-1:0]   ch_write_tx;
  logic [N-1:0]   ch_tx_full;
  logic [8*N-1:0] ch_rx_data;
  logic [N-1:0]   ch_rx_present;
  logic [N-1:0]   ch_read_ack;

  modport slave (
    input  IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    input  ch_tx_full, ch_rx_data, ch_rx_present,
    output IO_read_data, ch_tx_data, ch_write_tx, ch_read_ack
  );

  modport master (
    output IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    output ch_tx_full, ch_rx_data, ch_rx_present,
    input  IO_read_data, ch_tx_data, ch_write_tx, ch_read_ack
  );
endinterface

// File: rtl/io_port_hub.sv
// N-channel IO port hub.
// Each channel has a data port and a status/control port. Each channel also has
// a TX staging FIFO that drains into its UART at most once every two cycles.
// Read data is registered, and RX read acks are registered.
module io_port_hub #(
  parameter int          NUM_CHANNELS = 2,
  parameter logic [7:0]  DATA_BASE    = 8'h01,
  parameter logic [7:0]  STAT_BASE    = 8'h10,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic          clk100,
  input  logic          reset,
  io_port_hub_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_CHANNELS-1:0]   ovf;
  logic [NUM_CHANNELS-1:0]   fifo_empty;
  logic [NUM_CHANNELS-1:0]   fifo_full;
  logic [NUM_CHANNELS-1:0]   write_tx;
  logic [NUM_CHANNELS-1:0]   read_ack;
  logic [8*NUM_CHANNELS-1:0] tx_data;
  logic [7:0]                read_data_d;
  logic [7:0]                read_data_q;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic          data_hit;
      logic          stat_hit;
      logic          push;
      logic          ovf_set;
      logic          ovf_clr;
      logic          flush;
      logic          drain;
      logic [7:0]    mem_q [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr_q;
      logic [PW-1:0] rd_ptr_q;
      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;
      logic          ovf_q;
      logic          write_tx_q;
      logic          ack_q;
      logic [7:0]    tx_data_q;

      assign data_hit = (bus.IO_port_ID == 8'(DATA_BASE + gi));
      assign stat_hit = (bus.IO_port_ID == 8'(STAT_BASE + gi));

      // Occupancy before the edge decides whether a byte is accepted.
      // A drain in the same cycle does not make room for that byte.
      assign push    = bus.IO_write_strobe && data_hit && (count_q <  CW'(FIFO_DEPTH));
      assign ovf_set = bus.IO_write_strobe && data_hit && (count_q == CW'(FIFO_DEPTH));
      assign flush   = bus.IO_write_strobe && stat_hit && bus.IO_write_data[0];
      assign ovf_clr = (bus.IO_write_strobe && stat_hit && bus.IO_write_data[1]) ||
                       (bus.IO_read_strobe && stat_hit);
      // The gap after each pulse gives the UART time to raise its full flag.
      // A flush takes priority over any drain in the same cycle.
      assign drain   = (count_q != '0) && !bus.ch_tx_full[gi] && !write_tx_q && !flush;

      // Compute the next occupancy from the flush, push and pop events.
      always_comb begin
        count_d = count_q;
        if (flush) begin
          count_d = '0;
        end else if (push && !drain) begin
          count_d = count_q + CW'(1);
        end else if (!push && drain) begin
          count_d = count_q - CW'(1);
        end
      end

      // FIFO storage is written on an accepted push. It has no reset, so it can map to RAM.
      always_ff @(posedge clk100) begin
        if (push) begin
          mem_q[wr_ptr_q] <= bus.IO_write_data;
        end
      end

      // Update the pointers, the overflow flag, the TX output register and the RX ack.
      always_ff @(posedge clk100) begin
        if (!reset) begin
          wr_ptr_q   <= '0;
          rd_ptr_q   <= '0;
          count_q    <= '0;
          ovf_q      <= 1'b0;
          write_tx_q <= 1'b0;
          ack_q      <= 1'b0;
          tx_data_q  <= 8'h00;
        end else begin
          count_q    <= count_d;
          write_tx_q <= drain;
          ack_q      <= bus.IO_read_strobe && data_hit && bus.ch_rx_present[gi];
          if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else begin
            if (push) begin
              wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (drain) begin
              rd_ptr_q  <= rd_ptr_q + PW'(1);
              tx_data_q <= mem_q[rd_ptr_q];
            end
          end
          if (ovf_set) begin
            ovf_q <= 1'b1;
          end else if (ovf_clr) begin
            ovf_q <= 1'b0;
          end
        end
      end

      assign ovf[gi]              = ovf_q;
      assign fifo_empty[gi]       = (count_q == '0);
      assign fifo_full[gi]        = (count_q == CW'(FIFO_DEPTH));
      assign write_tx[gi]         = write_tx_q;
      assign read_ack[gi]         = ack_q;
      assign tx_data[8*gi +: 8]   = tx_data_q;
    end
  endgenerate

  // Decode the port address into read data. An unmapped port reads as zero.
  always_comb begin
    read_data_d = 8'h00;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (bus.IO_port_ID == 8'(DATA_BASE + i)) begin
        read_data_d = bus.ch_rx_data[8*i +: 8];
      end
      if (bus.IO_port_ID == 8'(STAT_BASE + i)) begin
        read_data_d = {4'b0000, ovf[i], fifo_empty[i], fifo_full[i], bus.ch_rx_present[i]};
      end
    end
  end

  // Register the read data every cycle, whether or not a strobe is present.
  always_ff @(posedge clk100) begin
    if (!reset) begin
      read_data_q <= 8'h00;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign bus.IO_read_data = read_data_q;
  assign bus.ch_write_tx  = write_tx;
  assign bus.ch_read_ack  = read_ack;
  assign bus.ch_tx_data   = tx_data;
endmodule
